stopwatch_ctrl_param: RTL and testbench
=======================================

Name: stopwatch_ctrl_param

Overview:
- Single-clock, parametrised stopwatch/timer controller. Keeps a minutes:seconds count with configurable limits.
- Supports count-up (saturating) and count-down (stops at zero, flags done) modes, a pause toggle, a user clear, and an adjust mode with a blink indicator.
- Rate control comes from one-cycle tick enables produced by the upstream clock-divider block. This block feeds the display/segment driver.

Parameters:
- SEC_MAX, 59, largest seconds value; seconds wraps SEC_MAX -> 0.
- MIN_MAX, 59, largest minutes value.
- SEC_W, 6, seconds field width; must satisfy 2**SEC_W > SEC_MAX.
- MIN_W, 6, minutes field width; must satisfy 2**MIN_W > MIN_MAX.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- count_tick  in  1  one-cycle enable, nominal 1 Hz; advances the count in RUN.
- adj_tick  in  1  one-cycle enable, nominal 2 Hz; advances the selected field in SET.
- blink_tick  in  1  one-cycle enable; toggles blink in SET.
- pause_btn  in  1  debounced, synchronised level; its rising edge toggles pause.
- clr_btn  in  1  debounced, synchronised level; its rising edge clears the count.
- adj  in  1  level; selects adjust mode.
- sel  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
- count_down  in  1  level; 1 = count down, 0 = count up.
- min  out  MIN_W  minutes value.
- sec  out  SEC_W  seconds value.
- blink  out  1  display blink phase; 0 outside SET.
- done  out  1  count-down reached 00:00.
- sat  out  1  count-up saturated at MIN_MAX:SEC_MAX.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=RUN, min=0, sec=0, blink=0, done=0, sat=0.
  - Edge-detect history registers = 0, so a button already held high at reset release does not fire.
- Edge detection: pause_rise and clr_rise = (previous-cycle level 0) & (current level 1). Each press gives one pulse.
- Priority in every state: clr_rise > pause_rise > adj level.
- States: RUN, PAUSE, SET, CLEAR.
- Transitions:
  - RUN: clr_rise -> CLEAR; pause_rise -> PAUSE; adj -> SET; otherwise stay.
  - SET: clr_rise -> CLEAR; pause_rise -> PAUSE; !adj -> RUN; otherwise stay.
  - PAUSE: clr_rise -> CLEAR; pause_rise -> SET if adj, else RUN; otherwise hold.
  - CLEAR: lasts exactly one cycle; zeroes min/sec and clears done/sat. Next state: pause_rise -> PAUSE; adj -> SET; otherwise RUN.
- Count update rule: a tick acts according to the current state in that cycle, even when the state changes in the same cycle. Ticks in PAUSE or CLEAR are ignored.
- RUN, count_tick, count-up:
  - sec<SEC_MAX: sec+1.
  - sec==SEC_MAX and min<MIN_MAX: sec=0, min+1.
  - At MIN_MAX:SEC_MAX: hold and set sat=1.
- RUN, count_tick, count-down:
  - sec>0: sec-1.
  - sec==0 and min>0: sec=SEC_MAX, min-1.
  - At 00:00: hold and set done=1.
- SET, adj_tick:
  - sel=1: sec increments, wrapping SEC_MAX -> 0, with no carry into min.
  - sel=0: min increments, wrapping MIN_MAX -> 0.
  - Any SET increment clears done and sat.
- blink:
  - Toggles on blink_tick only while in SET.
  - Forced to 0 in the same cycle the state leaves SET; enters SET at 0.
- done and sat:
  - Sticky until CLEAR, a SET increment, or a change of count_down.
  - A count_down change clears both one cycle after the change.
- Outputs are registered; min/sec change exactly one cycle after the qualifying tick.
- Asserting reset mid-operation immediately forces the reset values.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum (RUN, PAUSE, SET, CLEAR);
  - default limits SEC_MAX_DEF=59 and MIN_MAX_DEF=59;
  - width helper function (clog2-based).
- Sub-module rise_detect: single-bit rising-edge pulse with async active-high reset. Instantiate twice (pause_btn, clr_btn).
- Counter arithmetic stays inline.

Test Plan:
- Reset release, count-up, 61 count_ticks -> min=1, sec=1, done=0, sat=0.
- Force 59:58 via SET, exit to RUN, 3 count_ticks -> 59:59 after the 1st tick, held thereafter; sat=1 after the 2nd tick.
- count_down=1, set 01:00, 60 count_ticks -> 00:00, done=0. 61st tick -> held at 00:00, done=1. clr_btn pulse -> CLEAR for 1 cycle, then RUN, done=0.
- RUN at 00:10, pause_btn held 5 cycles with count_ticks present -> single PAUSE entry, count stays 00:10. Second press with adj=1 -> SET.
- SET, sel=1, sec=59, adj_tick -> sec=0 with min unchanged. sel=0, min=59, adj_tick -> min=0. blink toggles per blink_tick and is 0 the cycle after adj falls.
- clr_rise and pause_rise in the same cycle in RUN -> CLEAR. pause_btn still high next cycle -> no further edge, state=RUN (adj=0). Async reset mid-count -> outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_SET   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int unsigned SEC_MAX_DEF = 59;
  localparam int unsigned MIN_MAX_DEF = 59;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned field_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector; pulse is high for one cycle per 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise_c
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_rise_c = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl_param.sv
// Minutes:seconds stopwatch/timer with run, pause, adjust and clear modes.
// Ticks are one-cycle enables from the upstream divider; outputs are registered.
module stopwatch_ctrl_param
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MAX = SEC_MAX_DEF,
  parameter int unsigned MIN_MAX = MIN_MAX_DEF,
  parameter int unsigned SEC_W   = field_width(SEC_MAX_DEF),
  parameter int unsigned MIN_W   = field_width(MIN_MAX_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_tick,
  input  logic             adj_tick,
  input  logic             blink_tick,
  input  logic             pause_btn,
  input  logic             clr_btn,
  input  logic             adj,
  input  logic             sel,
  input  logic             count_down,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             blink,
  output logic             done,
  output logic             sat
);

  localparam logic [SEC_W-1:0] SEC_LIM = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_LIM = MIN_W'(MIN_MAX);

  logic w_pause_rise;
  logic w_clr_rise;

  rise_detect u_pause_rise (
    .clk      (clk),
    .reset    (reset),
    .i_level  (pause_btn),
    .o_rise_c (w_pause_rise)
  );

  rise_detect u_clr_rise (
    .clk      (clk),
    .reset    (reset),
    .i_level  (clr_btn),
    .o_rise_c (w_clr_rise)
  );

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MIN_W-1:0] r_min;
  logic [SEC_W-1:0] r_sec;
  logic             r_blink;
  logic             r_done;
  logic             r_sat;
  logic             r_cd_prev;
  logic [MIN_W-1:0] w_min_nxt;
  logic [SEC_W-1:0] w_sec_nxt;
  logic             w_blink_nxt;
  logic             w_done_nxt;
  logic             w_sat_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state; clear beats pause beats the adj level everywhere.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_clr_rise)        w_state_nxt = ST_CLEAR;
        else if (w_pause_rise) w_state_nxt = ST_PAUSE;
        else if (adj)          w_state_nxt = ST_SET;
      end
      ST_SET: begin
        if (w_clr_rise)        w_state_nxt = ST_CLEAR;
        else if (w_pause_rise) w_state_nxt = ST_PAUSE;
        else if (!adj)         w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_clr_rise)        w_state_nxt = ST_CLEAR;
        else if (w_pause_rise) w_state_nxt = adj ? ST_SET : ST_RUN;
      end
      ST_CLEAR: begin
        if (w_pause_rise)      w_state_nxt = ST_PAUSE;
        else if (adj)          w_state_nxt = ST_SET;
        else                   w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Count datapath; ticks act according to the state held during this cycle.
  always_comb begin
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_blink_nxt = 1'b0;
    w_done_nxt  = r_done;
    w_sat_nxt   = r_sat;
    case (r_state)
      ST_RUN: begin
        if (count_tick && !count_down) begin
          if (r_sec < SEC_LIM) begin
            w_sec_nxt = r_sec + SEC_W'(1);
          end else if (r_min < MIN_LIM) begin
            w_sec_nxt = '0;
            w_min_nxt = r_min + MIN_W'(1);
          end else begin
            w_sat_nxt = 1'b1;
          end
        end else if (count_tick) begin
          if (r_sec != '0) begin
            w_sec_nxt = r_sec - SEC_W'(1);
          end else if (r_min != '0) begin
            w_sec_nxt = SEC_LIM;
            w_min_nxt = r_min - MIN_W'(1);
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_SET: begin
        if (adj_tick) begin
          if (sel) w_sec_nxt = (r_sec >= SEC_LIM) ? '0 : r_sec + SEC_W'(1);
          else     w_min_nxt = (r_min >= MIN_LIM) ? '0 : r_min + MIN_W'(1);
          w_done_nxt = 1'b0;
          w_sat_nxt  = 1'b0;
        end
        // Blink drops to 0 on the same edge that leaves SET.
        if (w_state_nxt == ST_SET) w_blink_nxt = r_blink ^ blink_tick;
      end
      ST_CLEAR: begin
        w_min_nxt  = '0;
        w_sec_nxt  = '0;
        w_done_nxt = 1'b0;
        w_sat_nxt  = 1'b0;
      end
      default: ;
    endcase
    if (count_down != r_cd_prev) begin
      w_done_nxt = 1'b0;
      w_sat_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min     <= '0;
      r_sec     <= '0;
      r_blink   <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_cd_prev <= 1'b0;
    end else begin
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_blink   <= w_blink_nxt;
      r_done    <= w_done_nxt;
      r_sat     <= w_sat_nxt;
      r_cd_prev <= count_down;
    end
  end

  assign min   = r_min;
  assign sec   = r_sec;
  assign blink = r_blink;
  assign done  = r_done;
  assign sat   = r_sat;

endmodule

// File: tb/tb_stopwatch_ctrl_param.sv
// Directed bench for stopwatch_ctrl_param: a vector table plus hand sequences.
module tb_stopwatch_ctrl_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       count_tick, adj_tick, blink_tick, pause_btn, clr_btn, adj, sel, count_down;
  logic [5:0] min;
  logic [5:0] sec;
  logic       blink, done, sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Input vector bits: {ct, at, bt, pb, cb, adj, sel, cd}
  localparam logic [7:0] V_CT  = 8'b1000_0000;
  localparam logic [7:0] V_AT  = 8'b0100_0000;
  localparam logic [7:0] V_BT  = 8'b0010_0000;
  localparam logic [7:0] V_PB  = 8'b0001_0000;
  localparam logic [7:0] V_CB  = 8'b0000_1000;
  localparam logic [7:0] V_ADJ = 8'b0000_0100;
  localparam logic [7:0] V_SEL = 8'b0000_0010;
  localparam logic [7:0] V_CD  = 8'b0000_0001;
  localparam logic [7:0] V_NO  = 8'b0000_0000;

  typedef struct {
    logic [7:0] vin;
    logic [5:0] emin;
    logic [5:0] esec;
    logic       eblink;
    logic       edone;
    logic       esat;
  } vec_t;

  vec_t tbl[21];

  stopwatch_ctrl_param dut (
    .clk        (clk),
    .reset      (reset),
    .count_tick (count_tick),
    .adj_tick   (adj_tick),
    .blink_tick (blink_tick),
    .pause_btn  (pause_btn),
    .clr_btn    (clr_btn),
    .adj        (adj),
    .sel        (sel),
    .count_down (count_down),
    .min        (min),
    .sec        (sec),
    .blink      (blink),
    .done       (done),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] v);
    {count_tick, adj_tick, blink_tick, pause_btn, clr_btn, adj, sel, count_down} = v;
  endtask

  task automatic step(input logic [7:0] v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(V_NO);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [5:0] emin, input logic [5:0] esec,
                       input logic eblink, input logic edone, input logic esat);
    n_tests++;
    if ({min, sec, blink, done, sat} !== {emin, esec, eblink, edone, esat}) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d blink=%b done=%b sat=%b, expected %0d:%0d blink=%b done=%b sat=%b",
               name, min, sec, blink, done, sat, emin, esec, eblink, edone, esat);
    end
  endtask

  initial begin
    tbl[0]  = '{V_CT,                     6'd0, 6'd1,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{V_NO,                     6'd0, 6'd1,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{V_ADJ,                    6'd0, 6'd1,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{V_AT | V_ADJ | V_SEL,     6'd0, 6'd2,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{V_BT | V_ADJ,             6'd0, 6'd2,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{V_AT | V_BT | V_ADJ,      6'd1, 6'd2,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{V_CT | V_ADJ,             6'd1, 6'd2,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{V_BT | V_ADJ,             6'd1, 6'd2,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{V_BT,                     6'd1, 6'd2,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{V_CT | V_CD,              6'd1, 6'd1,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{V_CT | V_PB | V_CD,       6'd1, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{V_CT | V_PB | V_CD,       6'd1, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{V_CT | V_CD,              6'd1, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{V_PB | V_CD,              6'd1, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[14] = '{V_CT | V_CD,              6'd0, 6'd59, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{V_CT | V_CB | V_CD,       6'd0, 6'd58, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{V_CT | V_CB | V_CD,       6'd0, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[17] = '{V_CT | V_CD,              6'd0, 6'd0,  1'b0, 1'b1, 1'b0};
    tbl[18] = '{V_CD,                     6'd0, 6'd0,  1'b0, 1'b1, 1'b0};
    tbl[19] = '{V_NO,                     6'd0, 6'd0,  1'b0, 1'b0, 1'b0};
    tbl[20] = '{V_CT,                     6'd0, 6'd1,  1'b0, 1'b0, 1'b0};

    do_reset();
    check("reset", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].vin);
      check($sformatf("vec%0d", i), tbl[i].emin, tbl[i].esec, tbl[i].eblink,
            tbl[i].edone, tbl[i].esat);
    end

    // Count-up carry: 61 ticks -> 01:01.
    do_reset();
    for (int i = 0; i < 61; i++) step(V_CT);
    check("up_61", 6'd1, 6'd1, 1'b0, 1'b0, 1'b0);

    // Saturation at 59:59, then SET wrap and blink.
    do_reset();
    step(V_ADJ);
    for (int i = 0; i < 59; i++) step(V_ADJ | V_AT);
    for (int i = 0; i < 58; i++) step(V_ADJ | V_AT | V_SEL);
    step(V_NO);
    check("set_5958", 6'd59, 6'd58, 1'b0, 1'b0, 1'b0);
    step(V_CT);
    check("sat_t1", 6'd59, 6'd59, 1'b0, 1'b0, 1'b0);
    step(V_CT);
    check("sat_t2", 6'd59, 6'd59, 1'b0, 1'b0, 1'b1);
    step(V_CT);
    check("sat_t3", 6'd59, 6'd59, 1'b0, 1'b0, 1'b1);
    step(V_ADJ);
    step(V_ADJ | V_SEL | V_AT);
    check("sec_wrap", 6'd59, 6'd0, 1'b0, 1'b0, 1'b0);
    step(V_ADJ | V_AT);
    check("min_wrap", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(V_ADJ | V_BT);
    check("blink_on", 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    step(V_ADJ | V_BT);
    step(V_ADJ | V_BT);
    check("blink_on2", 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    step(V_NO);
    check("blink_exit", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Count-down from 01:00 to done, then clear.
    do_reset();
    step(V_ADJ);
    step(V_ADJ | V_AT);
    step(V_CD);
    check("set_0100", 6'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) step(V_CT | V_CD);
    check("down_60", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(V_CT | V_CD);
    check("down_61", 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    step(V_CB | V_CD);
    check("clr_enter", 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    step(V_CD);
    check("clr_done", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Held pause button gives a single PAUSE entry.
    do_reset();
    step(V_ADJ);
    for (int i = 0; i < 10; i++) step(V_ADJ | V_SEL | V_AT);
    step(V_NO);
    step(V_PB);
    for (int i = 0; i < 4; i++) step(V_PB | V_CT);
    check("pause_hold", 6'd0, 6'd10, 1'b0, 1'b0, 1'b0);
    step(V_CT);
    check("pause_rel", 6'd0, 6'd10, 1'b0, 1'b0, 1'b0);
    step(V_PB | V_ADJ);
    step(V_ADJ | V_SEL | V_AT);
    check("pause_to_set", 6'd0, 6'd11, 1'b0, 1'b0, 1'b0);

    // Simultaneous clear and pause edges in RUN: clear wins.
    step(V_NO);
    step(V_CB | V_PB);
    check("clr_pb_enter", 6'd0, 6'd11, 1'b0, 1'b0, 1'b0);
    step(V_CB | V_PB);
    check("clr_pb_zero", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(V_PB | V_CT);
    check("clr_pb_run", 6'd0, 6'd1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count.
    step(V_CT);
    check("pre_reset", 6'd0, 6'd2, 1'b0, 1'b0, 1'b0);
    drive(V_CT);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(V_NO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
